// File: rtl/imem_boot_loader.sv
// imem_boot_loader
//   Boot-time loader for the core's instruction memory. Collects a byte stream
//   (valid/ready), packs little-endian 32-bit words, writes them to consecutive
//   word addresses, and holds the core in reset until the requested number of
//   words is in memory. In RUN the memory address port follows the core PC.
//
// Ports
//   clk, rst_n          clock, async active-low reset
//   start, word_count   load request; count sampled when start is accepted
//   byte_valid/_data    input byte stream
//   byte_ready          byte accepted this cycle (LOAD only)
//   pc_address          core PC (byte address), used only in RUN
//   imem_addr/_wdata/_we  instruction-memory write/read port
//   cpu_rst_n           active-low core reset, high only in RUN
//   busy, done, error   status; error is sticky until the next valid start
//   pc_misaligned       RUN and PC not word aligned
module imem_boot_loader #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   word_count,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  input  logic [31:0]           pc_address,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  imem_we,
  output logic                  cpu_rst_n,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic                  pc_misaligned
);

  typedef enum logic [1:0] {IDLE, LOAD, WRITE, RUN} state_e;

  localparam logic [ADDR_WIDTH:0] CAP = {1'b1, {ADDR_WIDTH{1'b0}}};

  state_e              state_q, state_d;
  // One bit wider than the address so it compares directly against count-1.
  logic [ADDR_WIDTH:0] word_idx_q, word_idx_d;
  logic [ADDR_WIDTH:0] count_q, count_d;
  logic [1:0]          byte_idx_q, byte_idx_d;
  logic [31:0]         asm_q, asm_d;
  logic                error_q, error_d;
  logic                cpu_rst_n_q, cpu_rst_n_d;
  logic                start_ok;

  assign start_ok = (word_count != '0) && (word_count <= CAP);

  always_comb begin
    state_d    = state_q;
    word_idx_d = word_idx_q;
    count_d    = count_q;
    byte_idx_d = byte_idx_q;
    asm_d      = asm_q;
    error_d    = error_q;
    case (state_q)
      IDLE, RUN: begin
        if (start) begin
          if (start_ok) begin
            state_d    = LOAD;
            count_d    = word_count;
            word_idx_d = '0;
            byte_idx_d = '0;
            asm_d      = '0;
            error_d    = 1'b0;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      LOAD: begin
        if (byte_valid) begin
          asm_d[{byte_idx_q, 3'b000} +: 8] = byte_data;
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) state_d = WRITE;
        end
      end
      WRITE: begin
        if (word_idx_q == count_q - 1'b1) begin
          state_d = RUN;
        end else begin
          word_idx_d = word_idx_q + 1'b1;
          state_d    = LOAD;
        end
      end
      default: state_d = IDLE;
    endcase
    // Registered so the core sees a clean reset edge one cycle after the
    // state decision.
    cpu_rst_n_d = (state_d == RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      word_idx_q  <= '0;
      count_q     <= '0;
      byte_idx_q  <= '0;
      asm_q       <= '0;
      error_q     <= 1'b0;
      cpu_rst_n_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_idx_q  <= word_idx_d;
      count_q     <= count_d;
      byte_idx_q  <= byte_idx_d;
      asm_q       <= asm_d;
      error_q     <= error_d;
      cpu_rst_n_q <= cpu_rst_n_d;
    end
  end

  // PC drives the address only in RUN; upper PC bits wrap modulo capacity.
  assign imem_addr     = (state_q == RUN) ? pc_address[ADDR_WIDTH+1:2]
                                          : word_idx_q[ADDR_WIDTH-1:0];
  assign imem_wdata    = asm_q;
  assign imem_we       = (state_q == WRITE);
  assign byte_ready    = (state_q == LOAD);
  assign busy          = (state_q == LOAD) || (state_q == WRITE);
  assign done          = (state_q == RUN);
  assign error         = error_q;
  assign cpu_rst_n     = cpu_rst_n_q;
  assign pc_misaligned = (state_q == RUN) && (|pc_address[1:0]);

endmodule
